// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and run-state controller for the five-stage Y86-64 pipeline.
// Produces the stall/bubble controls for the F/D/E/M/W pipeline registers and the
// condition-code write enable. It also latches the halt/exception state.
// Optional feature macro: PIPE_CTRL_PERF_EN builds saturating performance counters.
// Without that macro the four counter outputs are tied to zero and no counter
// flops exist.
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [1:0]       m_stat,
    input  logic [3:0]       W_icode,
    input  logic [1:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             set_cc,
    output logic             halted,
    output logic [1:0]       halt_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [1:0] S_AOK    = 2'd0;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_STOP = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [1:0] halt_stat_r;

    logic load_use_s;
    logic ret_pend_s;
    logic mispred_s;
    logic w_exc_s;

    // Hazard detection from the pipeline register fields
    assign load_use_s = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                        (E_dstM != R_NONE) &&
                        ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign ret_pend_s = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign mispred_s  = (E_icode == I_JXX) && !e_Cnd;
    assign w_exc_s    = (W_stat != S_AOK);

    // Run-state register; STOP is only left through reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: an exception reaching W stops the machine
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (w_exc_s) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_STOP: state_nxt_s = ST_STOP;
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // Capture the status that caused the stop on the RUN->STOP edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halt_stat_r <= 2'd0;
        end else if ((state_r == ST_RUN) && w_exc_s) begin
            halt_stat_r <= W_stat;
        end else begin
            halt_stat_r <= halt_stat_r;
        end
    end

    assign halted    = (state_r == ST_STOP);
    assign halt_stat = halt_stat_r;

    // Pipeline control outputs; the flush pattern is the default and holds during reset
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        W_stall  = 1'b0;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        set_cc   = 1'b0;
        if (!rst_n) begin
            F_stall = 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    F_stall  = load_use_s | ret_pend_s;
                    D_stall  = load_use_s;
                    D_bubble = mispred_s | (ret_pend_s & ~load_use_s);
                    E_bubble = mispred_s | load_use_s;
                    M_bubble = (m_stat != S_AOK) | w_exc_s;
                    W_stall  = w_exc_s;
                    set_cc   = (E_icode == I_OPQ) & (m_stat == S_AOK) & ~w_exc_s;
                end
                ST_STOP: begin
                    F_stall  = 1'b1;
                    D_stall  = 1'b1;
                    W_stall  = 1'b1;
                    D_bubble = 1'b0;
                    E_bubble = 1'b1;
                    M_bubble = 1'b1;
                    set_cc   = 1'b0;
                end
                default: begin
                    F_stall = 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] cyc_cnt_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] mispred_cnt_r;
    logic [CNT_W-1:0] retire_cnt_r;
    logic             retire_s;

    assign retire_s = ~w_exc_s && (W_icode != I_NOP);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    // Saturating event counters, advancing only while running
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_cnt_r     <= {CNT_W{1'b0}};
            stall_cnt_r   <= {CNT_W{1'b0}};
            mispred_cnt_r <= {CNT_W{1'b0}};
            retire_cnt_r  <= {CNT_W{1'b0}};
        end else if (state_r == ST_RUN) begin
            cyc_cnt_r     <= sat_inc(cyc_cnt_r, 1'b1);
            stall_cnt_r   <= sat_inc(stall_cnt_r, load_use_s | ret_pend_s);
            mispred_cnt_r <= sat_inc(mispred_cnt_r, mispred_s);
            retire_cnt_r  <= sat_inc(retire_cnt_r, retire_s);
        end else begin
            cyc_cnt_r     <= cyc_cnt_r;
            stall_cnt_r   <= stall_cnt_r;
            mispred_cnt_r <= mispred_cnt_r;
            retire_cnt_r  <= retire_cnt_r;
        end
    end

    assign cyc_cnt     = cyc_cnt_r;
    assign stall_cnt   = stall_cnt_r;
    assign mispred_cnt = mispred_cnt_r;
    assign retire_cnt  = retire_cnt_r;
`else
    logic unused_perf_s;
    assign unused_perf_s = ^W_icode;
    assign cyc_cnt     = {CNT_W{1'b0}};
    assign stall_cnt   = {CNT_W{1'b0}};
    assign mispred_cnt = {CNT_W{1'b0}};
    assign retire_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Hazard and run-state controller for the five-stage Y86-64 pipeline. It watches the icode, register and status fields in the D, E, M and W pipeline registers, plus the execute-stage branch outcome. From these it drives the stall and bubble inputs of the F/D/E/M/W pipeline registers and the condition-code write enable. It also latches the machine halt/exception state and, optionally, keeps performance counters.

## Interface
- CNT_W, 32, width of each performance counter
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  synchronous active-low reset
- D_icode  in  4  icode in D register
- d_srcA, d_srcB  in  4  decode source registers (4'hF = none)
- E_icode  in  4  icode in E register
- E_dstM  in  4  memory destination register in E (4'hF = none)
- e_Cnd  in  1  branch/cmov condition from execute
- M_icode  in  4  icode in M register
- m_stat  in  2  status leaving memory stage
- W_icode  in  4  icode in W register
- W_stat  in  2  status in W register
- F_stall, D_stall, W_stall  out  1  hold register contents
- D_bubble, E_bubble, M_bubble  out  1  load NOP (icode 1, stat AOK)
- set_cc  out  1  condition-code write enable
- halted  out  1  machine stopped
- halt_stat  out  2  W_stat value that caused the stop
- cyc_cnt, stall_cnt, mispred_cnt, retire_cnt  out  CNT_W  performance counters

## Operation
- Status codes are 0 = AOK, 1 = HLT, 2 = ADR, 3 = INS.
- Icodes: MRMOVQ = 5, OPQ = 6, JXX = 7, RET = 9, POPQ = B.
- load_use = (E_icode is MRMOVQ or POPQ) and E_dstM != F and E_dstM equals d_srcA or d_srcB.
- ret_pend = RET present in D_icode, E_icode or M_icode.
- mispred = E_icode is JXX and e_Cnd = 0.
- State RUN:
  - F_stall = load_use | ret_pend
  - D_stall = load_use
  - D_bubble = mispred | (ret_pend & ~load_use)
  - E_bubble = mispred | load_use
  - M_bubble = (m_stat != AOK) | (W_stat != AOK)
  - W_stall = W_stat != AOK
  - set_cc = (E_icode == OPQ) & m_stat == AOK & W_stat == AOK
- RUN → STOP on the clock edge where W_stat != AOK. On that edge halt_stat latches W_stat and halted goes to 1.
- State STOP:
  - F_stall, D_stall, W_stall = 1
  - E_bubble, M_bubble = 1
  - D_bubble = 0, set_cc = 0
  - STOP is left only by reset.
- Combined hazards follow the equations as written:
  - load_use and ret_pend together: stall F and D, bubble E, no D bubble.
  - ret in D with mispredict in E: F_stall, D_bubble and E_bubble are all set.
- Stall and bubble on the same register are never both asserted.

## Timing
- All control outputs are combinational from the inputs and the state register. They take effect at the same cycle's clock edge with zero-cycle latency.
- State, halt_stat and the counters are registered at the posedge of clk.
- While rst_n = 0, outputs are forced to a flush pattern regardless of inputs:
  - D_bubble, E_bubble, M_bubble = 1
  - all stalls = 0, set_cc = 0
- At the first edge with rst_n = 0:
  - state = RUN, halted = 0, halt_stat = 0
  - all counters = 0
- Reset is honoured in any state, including mid-stall and STOP.
- halted rises one edge after W_stat first becomes non-AOK. W_stall is already 1 in that same cycle.
- Load-use costs exactly 1 stall cycle. Ret costs 3 F-stall cycles. Mispredict costs 2 bubbles, one in D and one in E.

## Configuration
- PIPE_CTRL_PERF_EN defined: the counters are live. All counters saturate at 2^CNT_W − 1 and freeze in STOP.
  - cyc_cnt: +1 every RUN cycle
  - stall_cnt: +1 per RUN cycle with F_stall
  - mispred_cnt: +1 per RUN cycle with mispred
  - retire_cnt: +1 per RUN cycle where W_stat = AOK and W_icode != 1
- PIPE_CTRL_PERF_EN undefined: no counter flops are built, and all four counter outputs are constant 0.

## Test plan
- Load-use: E_icode = 5 with E_dstM = 3, d_srcA = 3, D_icode = 6 → F_stall = D_stall = E_bubble = 1 and D_bubble = 0 for exactly one cycle. With PIPE_CTRL_PERF_EN, stall_cnt = 1.
- Ret: feed RET through D, E, M on successive cycles → F_stall = 1 and D_bubble = 1 for 3 cycles, then 0.
- Mispredict: E_icode = 7, e_Cnd = 0 → D_bubble = E_bubble = 1 and F_stall = 0. With e_Cnd = 1, all outputs are 0.
- Combination: D_icode = 9 with E_icode = 7 and e_Cnd = 0 → F_stall, D_bubble and E_bubble are 1.
- Exception: m_stat = 2 → M_bubble = 1 and set_cc = 0 even with E_icode = 6. Next cycle W_stat = 2 → W_stall = 1; after the edge, halted = 1 and halt_stat = 2, and the outputs stay in the STOP pattern for 10+ cycles.
- Reset in STOP: drive rst_n = 0 for one cycle → flush pattern during reset; afterwards halted = 0, state RUN, counters = 0.
